// File: rtl/btn_blink_rate_sel.sv
// rtl/btn_blink_rate_sel.sv - pushbutton debounce and blink-rate mode select for the LED blinker
// Optional long-press return to mode 0 is built when LONG_PRESS_EN is defined.
module btn_blink_rate_sel #(
  parameter int DEBOUNCE_CYCLES   = 1000000,
  parameter int HALF_PERIOD_BASE  = 50000000,
  parameter int LONG_PRESS_CYCLES = 200000000
) (
  input  logic        CLK100MHZ,
  input  logic        RST,
  input  logic        BTN,
  output logic        press_pulse,
  output logic [1:0]  mode,
  output logic [26:0] half_period,
  output logic        blink_en,
  output logic        long_pulse
);

  localparam logic [26:0] DB_LAST = 27'(DEBOUNCE_CYCLES - 1);
  localparam logic [26:0] HP_BASE = 27'(HALF_PERIOD_BASE);

  typedef enum logic [1:0] {
    IDLE,
    CHECK_PRESS,
    PRESSED,
    CHECK_RELEASE
  } state_t;

  state_t      state;
  logic [26:0] cnt;
  logic        sync1;
  logic        sync2;

`ifdef LONG_PRESS_EN
  localparam logic [31:0] LP_LAST = 32'(LONG_PRESS_CYCLES - 1);
  logic [31:0] hold_cnt;
  logic        long_done;
`endif

  always_ff @(posedge CLK100MHZ) begin
    if (RST) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= BTN;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (RST) begin
      state       <= IDLE;
      cnt         <= '0;
      mode        <= 2'd0;
      press_pulse <= 1'b0;
`ifdef LONG_PRESS_EN
      hold_cnt    <= '0;
      long_done   <= 1'b0;
      long_pulse  <= 1'b0;
`endif
    end else begin
      press_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (sync2) begin
            state <= CHECK_PRESS;
            cnt   <= '0;
          end
        end
        CHECK_PRESS: begin
          if (!sync2) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == DB_LAST) begin
            state       <= PRESSED;
            cnt         <= '0;
            press_pulse <= 1'b1;
            mode        <= mode + 2'd1;
          end else begin
            cnt <= cnt + 27'd1;
          end
        end
        PRESSED: begin
          if (!sync2) begin
            state <= CHECK_RELEASE;
            cnt   <= '0;
          end
        end
        CHECK_RELEASE: begin
          if (sync2) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt == DB_LAST) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 27'd1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
`ifdef LONG_PRESS_EN
      // Hold time survives release bounce; only a fully accepted release re-arms it.
      long_pulse <= 1'b0;
      if (state == IDLE) begin
        hold_cnt  <= '0;
        long_done <= 1'b0;
      end else if (state == PRESSED && !long_done) begin
        if (hold_cnt == LP_LAST) begin
          long_pulse <= 1'b1;
          long_done  <= 1'b1;
          mode       <= 2'd0;
        end else begin
          hold_cnt <= hold_cnt + 32'd1;
        end
      end
`endif
    end
  end

`ifndef LONG_PRESS_EN
  // LONG_PRESS_CYCLES has no effect in this build.
  assign long_pulse = 1'b0 & (LONG_PRESS_CYCLES > 0);
`endif

  always_comb begin
    half_period = HP_BASE;
    blink_en    = 1'b1;
    case (mode)
      2'd0: half_period = HP_BASE;
      2'd1: half_period = HP_BASE >> 1;
      2'd2: half_period = HP_BASE >> 2;
      default: begin
        half_period = HP_BASE;
        blink_en    = 1'b0;
      end
    endcase
  end

endmodule
